// File: rtl/hpc1_mul_stream_pkg.sv
// hpc1_mul_stream_pkg: shared constants and GF(2^n) helpers for the HPC1 stream multiplier
// Contents: pipeline base latency, cross-term randomness indexing
// (num_quad/qindex), field polynomial selection and the generic
// shift-and-add field multiplier used by every lane.
package hpc1_mul_stream_pkg;
  localparam int HPC1_STREAM_LATENCY_BASE = 2;
  function automatic int num_quad(int n);
    return n * (n - 1) / 2;
  endfunction
  // One random element per unordered share pair; (i,j) and (j,i) share it so it cancels on compression.
  function automatic int qindex(int i, int j, int n);
    int lo, hi;
    lo = i < j ? i : j;
    hi = i < j ? j : i;
    return i == j ? 0 : lo * n - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction
  // Irreducible polynomial including the x^w term; width 8 is the AES polynomial.
  function automatic logic [31:0] field_poly(int w);
    return w == 2 ? 32'h7 : w == 3 ? 32'hb : w == 4 ? 32'h13 : w == 5 ? 32'h25 :
           w == 6 ? 32'h43 : w == 7 ? 32'h83 : 32'h11b;
  endfunction
  function automatic logic [31:0] generic_mul(logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] acc, x, poly;
    acc = '0;
    x = a;
    poly = field_poly(w);
    for (int k = 0; k < 32; k++)
      if (k < w) begin
        acc ^= b[k] ? x : '0;
        x = (x << 1) ^ (x[w-1] ? poly : '0);
      end
    return acc;
  endfunction
endpackage

// File: rtl/hpc1_mul_stream_if.sv
// hpc1_mul_stream_if: valid/ready stream bundle for the HPC1 multiplier
// Signals: in_valid/out_ready (input handshake), in_a/in_b/in_r/in_p (shared
// operands and randomness), out_valid/in_ready (output handshake), out_c (shared product).
// Modports: master = upstream/downstream environment, slave = multiplier.
interface hpc1_mul_stream_if
  import hpc1_mul_stream_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2,
  parameter int NUM_LANES  = 1
);
  localparam int SW = NUM_LANES * NUM_SHARES * BIT_WIDTH;
  localparam int PW = NUM_LANES * num_quad(NUM_SHARES) * BIT_WIDTH;
  logic          in_valid, out_ready, out_valid, in_ready;
  logic [SW-1:0] in_a, in_b, in_r, out_c;
  logic [PW-1:0] in_p;
  modport master (
    output in_valid, in_a, in_b, in_r, in_p, in_ready,
    input  out_ready, out_valid, out_c
  );
  modport slave (
    input  in_valid, in_a, in_b, in_r, in_p, in_ready,
    output out_ready, out_valid, out_c
  );
endinterface

// File: rtl/hpc1_mul_stream_lane.sv
// hpc1_mul_stream_lane: one lane's stage-1 (refresh/capture) and stage-2 (cross products) datapath
// Ports: clk, rst_n (async active-low), en1 (stage-1 load), en2 (stage-2 load),
// a/b/r (shared operands and refresh mask), p (cross-term randomness),
// c (compressed shared product taken from the stage-2 registers).
module hpc1_mul_stream_lane
  import hpc1_mul_stream_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en1,
  input  logic                                     en2,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]          a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]          b,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]          r,
  input  logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0] p,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]          c
);
  localparam int NQ = num_quad(NUM_SHARES);
  typedef logic [BIT_WIDTH-1:0] elem_t;
  typedef elem_t [NUM_SHARES-1:0] share_vec_t;
  share_vec_t                   a_ref, b_q;
  elem_t      [NQ-1:0]          p_q;
  share_vec_t [NUM_SHARES-1:0]  t_d, t_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_ref <= '0;
      b_q   <= '0;
      p_q   <= '0;
    end else if (en1) begin
      a_ref <= a ^ r;
      b_q   <= b;
      p_q   <= p;
    end
  always_comb begin
    t_d = '0;
    for (int i = 0; i < NUM_SHARES; i++)
      for (int j = 0; j < NUM_SHARES; j++)
        t_d[i][j] = elem_t'(generic_mul(32'(a_ref[i]), 32'(b_q[j]), BIT_WIDTH)) ^
                    (i != j ? p_q[qindex(i, j, NUM_SHARES)] : '0);
  end
  // Every share term is registered before compression so no share mixing happens through glitches upstream.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) t_q <= '0;
    else if (en2) t_q <= t_d;
  always_comb begin
    c = '0;
    for (int i = 0; i < NUM_SHARES; i++)
      for (int j = 0; j < NUM_SHARES; j++)
        c[i*BIT_WIDTH +: BIT_WIDTH] ^= t_q[i][j];
  end
endmodule

// File: rtl/hpc1_mul_stream.sv
// hpc1_mul_stream: pipelined multi-lane HPC1 masked GF(2^BIT_WIDTH) multiplier with valid/ready back-pressure
// Ports: in_clock (rising edge), in_reset (async active-low), bus (slave modport:
// in_valid/out_ready accept side, in_a/in_b/in_r/in_p operands and randomness,
// out_valid/in_ready output side, out_c shared product per lane).
// Option: define HPC1_STREAM_OUT_REG_EN to register the compressed shares
// (latency 3, glitch-free out_c); default build has latency 2.
module hpc1_mul_stream
  import hpc1_mul_stream_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2,
  parameter int NUM_LANES  = 1
) (
  input  logic              in_clock,
  input  logic              in_reset,
  hpc1_mul_stream_if.slave  bus
);
  localparam int SW = NUM_SHARES * BIT_WIDTH;
  localparam int PW = num_quad(NUM_SHARES) * BIT_WIDTH;
  logic                    v1, v2, acc2, down2, adv1, accept;
  logic [NUM_LANES*SW-1:0] c2;
  // acc2: stage 2 can take new data; down2: whatever follows stage 2 can take its data.
  assign acc2 = !v2 || down2;
  assign adv1 = v1 && acc2;
  assign bus.out_ready = !v1 || acc2;
  assign accept = bus.in_valid && bus.out_ready;
  always_ff @(posedge in_clock or negedge in_reset)
    if (!in_reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept || (v1 && !acc2);
      v2 <= v1 || (v2 && !down2);
    end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    hpc1_mul_stream_lane #(
      .NUM_SHARES(NUM_SHARES),
      .BIT_WIDTH (BIT_WIDTH)
    ) u_lane (
      .clk  (in_clock),
      .rst_n(in_reset),
      .en1  (accept),
      .en2  (adv1),
      .a    (bus.in_a[g*SW +: SW]),
      .b    (bus.in_b[g*SW +: SW]),
      .r    (bus.in_r[g*SW +: SW]),
      .p    (bus.in_p[g*PW +: PW]),
      .c    (c2[g*SW +: SW])
    );
  end
`ifdef HPC1_STREAM_OUT_REG_EN
  logic                    v3;
  logic [NUM_LANES*SW-1:0] c3;
  assign down2 = !v3 || bus.in_ready;
  always_ff @(posedge in_clock or negedge in_reset)
    if (!in_reset) begin
      v3 <= 1'b0;
      c3 <= '0;
    end else begin
      v3 <= v2 || (v3 && !bus.in_ready);
      if (v2 && down2) c3 <= c2;
    end
  assign bus.out_valid = v3;
  assign bus.out_c = c3;
`else
  assign down2 = bus.in_ready;
  assign bus.out_valid = v2;
  assign bus.out_c = c2;
`endif
endmodule

// File: tb/tb_hpc1_mul_stream.sv
// tb_hpc1_mul_stream: scoreboard bench for the HPC1 stream multiplier (GF(4) directed + GF(16) 3-share/4-lane)
module tb_hpc1_mul_stream;
`ifdef HPC1_STREAM_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int WS = 3, WB = 4, WL = 4, WQ = 3;
  localparam int WSW = WL * WS * WB, WPW = WL * WQ * WB;
  typedef struct {logic [1:0] exp; int acc;} exp_d_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0, n_out = 0, last_lat = 0, last_out = 0;
  bit wide_bp = 1'b0;
  exp_d_t q_d[$];
  logic [WL*WB-1:0] q_w[$];
  exp_d_t e_d;
  logic [WL*WB-1:0] got_w;
  int tv[9][7];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  hpc1_mul_stream_if #(.NUM_SHARES(2), .BIT_WIDTH(2), .NUM_LANES(1)) bus();
  hpc1_mul_stream_if #(.NUM_SHARES(WS), .BIT_WIDTH(WB), .NUM_LANES(WL)) bus_w();
  hpc1_mul_stream #(.NUM_SHARES(2), .BIT_WIDTH(2), .NUM_LANES(1)) dut (
    .in_clock(clk), .in_reset(rst_n), .bus(bus));
  hpc1_mul_stream #(.NUM_SHARES(WS), .BIT_WIDTH(WB), .NUM_LANES(WL)) dut_w (
    .in_clock(clk), .in_reset(rst_n), .bus(bus_w));
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h at cycle %0d", name, got, req, cyc);
    end
  endtask
  // Carry-less product followed by long-division reduction.
  function automatic logic [3:0] ref_mul(logic [3:0] a, logic [3:0] b, int w, logic [7:0] poly);
    logic [7:0] prod;
    prod = '0;
    for (int k = 0; k < 4; k++) if (b[k]) prod ^= 8'(a) << k;
    for (int k = 7; k >= 0; k--) if (k >= w && prod[k]) prod ^= poly << (k - w);
    return prod[3:0];
  endfunction
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.in_ready) begin
      if (q_d.size() == 0) check("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
      else begin
        e_d = q_d.pop_front();
        check("product", 64'(bus.out_c[1:0] ^ bus.out_c[3:2]), 64'(e_d.exp));
        last_lat = cyc + 1 - e_d.acc;
        last_out = cyc + 1;
        n_out++;
      end
    end
  always @(negedge clk)
    if (rst_n && bus_w.out_valid && bus_w.in_ready) begin
      if (q_w.size() == 0) check("unexpected_out_valid_w", 64'(bus_w.out_valid), 64'(0));
      else begin
        got_w = '0;
        for (int l = 0; l < WL; l++)
          for (int s = 0; s < WS; s++)
            got_w[l*WB +: WB] ^= bus_w.out_c[(l*WS+s)*WB +: WB];
        check("product_w", 64'(got_w), 64'(q_w.pop_front()));
      end
    end
  initial forever begin
    @(posedge clk);
    #2;
    if (wide_bp) bus_w.in_ready = ($urandom_range(0, 3) != 0);
  end
  task automatic set_d(input int t);
    bus.in_a = {2'(tv[t][1]), 2'(tv[t][0])};
    bus.in_b = {2'(tv[t][3]), 2'(tv[t][2])};
    bus.in_r = {2'(tv[t][4]), 2'(tv[t][4])};
    bus.in_p = 2'(tv[t][5]);
    bus.in_valid = 1'b1;
  endtask
  task automatic push_d(input int t);
    exp_d_t e;
    e.exp = 2'(tv[t][6]);
    e.acc = cyc;
    q_d.push_back(e);
  endtask
  task automatic send_tv(input int t, output logic rdy0);
    set_d(t);
    @(negedge clk);
    rdy0 = bus.out_ready;
    for (int i = 0; i < 50 && !bus.out_ready; i++) @(negedge clk);
    if (!bus.out_ready) check("accept_timeout", 64'(bus.out_ready), 64'(1));
    else begin
      @(posedge clk);
      #1;
      push_d(t);
    end
  endtask
  task automatic send_w(input logic [WSW-1:0] a, b, r, input logic [WPW-1:0] p, input logic [WL*WB-1:0] e);
    bus_w.in_a = a;
    bus_w.in_b = b;
    bus_w.in_r = r;
    bus_w.in_p = p;
    bus_w.in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !bus_w.out_ready; i++) @(negedge clk);
    if (!bus_w.out_ready) check("accept_timeout_w", 64'(bus_w.out_ready), 64'(1));
    else begin
      @(posedge clk);
      #1;
      q_w.push_back(e);
    end
  endtask
  initial begin
    logic r0, rd, have;
    logic [3:0] snap;
    int idx, n0, a0;
    logic [WSW-1:0] wa, wb, wr;
    logic [WPW-1:0] wp;
    logic [WL*WB-1:0] we;
    logic [3:0] ua, ub;
    // a0, a1, b0, b1, r (both shares), p, expected unmasked product in GF(4)
    tv = '{'{0,1,2,0,1,3,2}, '{3,1,1,3,2,0,3}, '{2,1,3,0,3,2,2}, '{1,1,2,1,1,1,0},
           '{0,3,1,3,0,3,1}, '{2,0,0,1,2,2,2}, '{1,2,3,2,1,0,3}, '{2,3,1,2,3,1,3},
           '{1,3,0,3,2,1,1}};
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_r = '0; bus.in_p = '0; bus.in_ready = 1;
    bus_w.in_valid = 0; bus_w.in_a = '0; bus_w.in_b = '0; bus_w.in_r = '0; bus_w.in_p = '0; bus_w.in_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_c", 64'(bus.out_c), 64'(0));
    check("reset_out_ready", 64'(bus.out_ready), 64'(1));
    rst_n = 1'b1;
    // single transaction: a=2, b=3 -> 1
    n0 = n_out;
    send_tv(8, r0);
    bus.in_valid = 0;
    for (int i = 0; i < 20 && n_out == n0; i++) @(posedge clk);
    #1;
    check("single_count", 64'(n_out), 64'(n0 + 1));
    check("single_latency", 64'(last_lat), 64'(LAT));
    // back-to-back stream
    n0 = n_out;
    for (int t = 0; t < 8; t++) begin
      send_tv(t, r0);
      if (t == 0) a0 = cyc;
      check("stream_out_ready", 64'(r0), 64'(1));
    end
    bus.in_valid = 0;
    for (int i = 0; i < 40 && n_out != n0 + 8; i++) @(posedge clk);
    #1;
    check("stream_count", 64'(n_out), 64'(n0 + 8));
    check("stream_continuous", 64'(last_out), 64'(a0 + 7 + LAT));
    // back-pressure: downstream stalls while input keeps offering
    bus.in_ready = 0;
    idx = 0;
    have = 0;
    snap = '0;
    set_d(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd = bus.out_ready;
      check("bp_out_ready", 64'(rd), 64'(k < LAT));
      if (bus.out_valid) begin
        if (have) check("bp_out_c_stable", 64'(bus.out_c), 64'(snap));
        else begin
          snap = bus.out_c;
          have = 1;
        end
      end
      @(posedge clk);
      #1;
      if (rd) begin
        push_d(idx);
        idx++;
        if (idx < 4) set_d(idx);
      end
    end
    check("bp_valid_seen", 64'(have), 64'(1));
    bus.in_ready = 1;
    while (idx < 4) begin
      send_tv(idx, r0);
      idx++;
    end
    bus.in_valid = 0;
    for (int i = 0; i < 40 && q_d.size() != 0; i++) @(posedge clk);
    #1;
    check("bp_drained", 64'(q_d.size()), 64'(0));
    // reset with both stages occupied
    bus.in_ready = 0;
    send_tv(0, r0);
    send_tv(1, r0);
    bus.in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_out_c", 64'(bus.out_c), 64'(0));
    q_d.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.in_ready = 1;
    n0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_after_reset", 64'(n_out), 64'(n0));
    check("post_reset_out_ready", 64'(bus.out_ready), 64'(1));
    // 3 shares, 4 lanes, GF(16); odd transactions reuse a/b with fresh r/p
    wide_bp = 1;
    wa = '0;
    wb = '0;
    for (int t = 0; t < 100; t++) begin
      if (t % 2 == 0) begin
        wa = WSW'({$urandom(), $urandom()});
        wb = WSW'({$urandom(), $urandom()});
      end
      wr = WSW'({$urandom(), $urandom()});
      wp = WPW'({$urandom(), $urandom()});
      we = '0;
      for (int l = 0; l < WL; l++) begin
        wr[(l*WS+WS-1)*WB +: WB] = '0;
        for (int s = 0; s < WS - 1; s++) wr[(l*WS+WS-1)*WB +: WB] ^= wr[(l*WS+s)*WB +: WB];
        ua = '0;
        ub = '0;
        for (int s = 0; s < WS; s++) begin
          ua ^= wa[(l*WS+s)*WB +: WB];
          ub ^= wb[(l*WS+s)*WB +: WB];
        end
        we[l*WB +: WB] = ref_mul(ua, ub, 4, 8'h13);
      end
      send_w(wa, wb, wr, wp, we);
      if ($urandom_range(0, 3) == 0) begin
        bus_w.in_valid = 0;
        @(posedge clk);
        #1;
      end
    end
    bus_w.in_valid = 0;
    wide_bp = 0;
    @(posedge clk);
    #3;
    bus_w.in_ready = 1;
    for (int i = 0; i < 200 && (q_d.size() != 0 || q_w.size() != 0); i++) @(posedge clk);
    #1;
    check("final_drain_w", 64'(q_w.size()), 64'(0));
    check("final_drain_d", 64'(q_d.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
